divisor_ctrl: RTL

DIVISOR_CTRL -- requirements
Module: divisor_ctrl

---
 rtl/divisor_pkg.sv | 18 +
 rtl/divisor_pulso_btn.sv | 22 ++
 rtl/divisor_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/divisor_pkg.sv
// Shared definitions for the divisor controller and its external datapath:
// data width, operand type and FSM state encodings.
package divisor_pkg;

   localparam int unsigned DATA_W = 4;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      CARGA_NUM = 3'd0,
      CARGA_DEN = 3'd1,
      CALC      = 3'd2,
      VER_COC   = 3'd3,
      VER_RES   = 3'd4,
      ERROR     = 3'd5
   } state_t;

endpackage

// File: rtl/divisor_pulso_btn.sv
// Rising-edge detector for a synchronous button level: one-cycle pulse per press.
module pulso_btn (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = in;
      pulse  = in & ~prev_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= prev_d;
   end

endmodule

// File: rtl/divisor_ctrl.sv
// Operand entry / result display controller for an external 4-bit divider:
// edit num and den with up/down, launch the divide, then step through quotient and remainder.
module divisor_ctrl
   import divisor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              up,
   input  logic              down,
   input  logic              ok,
   output logic [DATA_W-1:0] leds,
   output logic              err,
   output logic              div_start,
   output logic [DATA_W-1:0] div_num,
   output logic [DATA_W-1:0] div_den,
   input  logic              div_done,
   input  logic [DATA_W-1:0] div_quot,
   input  logic [DATA_W-1:0] div_rem,
   output logic [2:0]        state
);

   state_t state_q, state_d;
   data_t  num_q, num_d;
   data_t  den_q, den_d;
   data_t  quot_q, quot_d;
   data_t  rem_q, rem_d;
   logic   start_q, start_d;

   logic up_ev, down_ev, ok_ev;
   logic inc, dec;

   pulso_btn u_up   (.clk(clk), .rst(rst), .in(up),   .pulse(up_ev));
   pulso_btn u_down (.clk(clk), .rst(rst), .in(down), .pulse(down_ev));
   pulso_btn u_ok   (.clk(clk), .rst(rst), .in(ok),   .pulse(ok_ev));

   // Simultaneous up and down cancel each other out.
   assign inc = up_ev & ~down_ev;
   assign dec = down_ev & ~up_ev;

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      den_d   = den_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      start_d = 1'b0;
      case (state_q)
         CARGA_NUM: begin
            if (ok_ev)    state_d = CARGA_DEN;
            else if (inc) num_d   = num_q + data_t'(1);
            else if (dec) num_d   = num_q - data_t'(1);
         end
         CARGA_DEN: begin
            if (ok_ev) begin
               if (den_q != '0) begin
                  state_d = CALC;
                  start_d = 1'b1;
               end else begin
                  state_d = ERROR;
               end
            end
            else if (inc) den_d = den_q + data_t'(1);
            else if (dec) den_d = den_q - data_t'(1);
         end
         CALC: begin
            if (div_done) begin
               quot_d  = div_quot;
               rem_d   = div_rem;
               state_d = VER_COC;
            end
         end
         VER_COC: if (ok_ev) state_d = VER_RES;
         VER_RES: begin
            if (ok_ev) begin
               state_d = CARGA_NUM;
               num_d   = '0;
               den_d   = '0;
            end
         end
         ERROR:   if (ok_ev) state_d = CARGA_DEN;
         default: state_d = CARGA_NUM;
      endcase
   end

   always_comb begin
      leds = '0;
      case (state_q)
         CARGA_NUM: leds = num_q;
         CARGA_DEN: leds = den_q;
         VER_COC:   leds = quot_q;
         VER_RES:   leds = rem_q;
         default:   leds = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CARGA_NUM;
         num_q   <= '0;
         den_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         den_q   <= den_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         start_q <= start_d;
      end
   end

   // Operands are frozen while in CALC since edits are only accepted in the load states.
   assign div_num   = num_q;
   assign div_den   = den_q;
   assign div_start = start_q;
   assign err       = (state_q == ERROR);
   assign state     = state_q;

endmodule
